// File: rtl/tft_pkg.sv
// Shared definitions for the TFT SPI byte transmitter: D/C flag encodings,
// frame state encoding and a small helper for the half-period phase.
package tft_pkg;

    localparam logic DC_COMM = 1'b0;
    localparam logic DC_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } tx_state_e;

    localparam logic [3:0] LAST_HALF = 4'd15;

    // Odd half-periods are the ones with sck high.
    function automatic logic is_rise_half(input logic [3:0] half);
        return half[0];
    endfunction

endpackage

// File: rtl/tft_spi_byte_tx_if.sv
// Request handshake between the init/draw sequencers (master) and the
// SPI byte transmitter (slave).
interface tft_spi_byte_tx_if;

    logic       tft_transmit;
    logic       tft_dc;
    logic [7:0] tft_data;
    logic       tft_busy;

    modport master (output tft_transmit, output tft_dc, output tft_data, input tft_busy);
    modport slave  (input tft_transmit, input tft_dc, input tft_data, output tft_busy);

endinterface

// File: rtl/tft_half_period_timer.sv
// Free-running period timer: counts 0..last while tick is high and pulses
// expire on the final count; load holds it at zero.
module tft_half_period_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         tick,
    input  logic [W-1:0] last,
    output logic         expire
);

    logic [W-1:0] cnt_r;

    assign expire = tick && (cnt_r == last);

    // Period counter, wraps to zero on expiry so consecutive periods chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {W{1'b0}};
        end else if (load || expire) begin
            cnt_r <= {W{1'b0}};
        end else if (tick) begin
            cnt_r <= cnt_r + W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/tft_spi_byte_tx.sv
// SPI mode-0 byte transmitter for the TFT panel, MSB first, with CS hold and
// idle gap. Optional read-back path enabled by defining TFT_SPI_READ_EN.
module tft_spi_byte_tx
    import tft_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic              clk,
    input  logic              rst,
    tft_spi_byte_tx_if.slave  bus,
    output logic              lcd_sck,
    output logic              lcd_mosi,
    output logic              lcd_dc,
    output logic              lcd_cs_n
`ifdef TFT_SPI_READ_EN
    ,
    input  logic              lcd_miso,
    output logic [7:0]        rx_data,
    output logic              rx_valid
`endif
);

    // One timer serves the half-periods, HOLD and GAP, so it is sized for the longer.
    localparam int MAX_LEN = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int TW      = $clog2(MAX_LEN + 1);
    localparam logic [TW-1:0] DIV_LAST = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(CS_GAP - 1);

    tx_state_e   state_r, state_nxt_s;
    logic [3:0]  bit_r, bit_nxt_s, half_nxt_s;
    logic [7:0]  shift_r, shift_nxt_s;
    logic        sck_r, sck_nxt_s;
    logic        mosi_r, mosi_nxt_s;
    logic        dc_r, dc_nxt_s;
    logic        cs_n_r, cs_n_nxt_s;
    logic        busy_r, busy_nxt_s;
    logic        tmr_load_s, expire_s;
    logic [TW-1:0] last_s;

    assign tmr_load_s = (state_r == IDLE);
    assign last_s     = (state_r == GAP) ? GAP_LAST : DIV_LAST;

    tft_half_period_timer #(.W(TW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load_s),
        .tick   (!tmr_load_s),
        .last   (last_s),
        .expire (expire_s)
    );

    // Next-state and next-output decode; outputs are registered below.
    always_comb begin
        state_nxt_s = state_r;
        bit_nxt_s   = bit_r;
        half_nxt_s  = bit_r + 4'd1;
        shift_nxt_s = shift_r;
        sck_nxt_s   = sck_r;
        mosi_nxt_s  = mosi_r;
        dc_nxt_s    = dc_r;
        cs_n_nxt_s  = cs_n_r;
        busy_nxt_s  = busy_r;
        case (state_r)
            IDLE: begin
                if (bus.tft_transmit) begin
                    state_nxt_s = SHIFT;
                    bit_nxt_s   = 4'd0;
                    shift_nxt_s = bus.tft_data;
                    dc_nxt_s    = bus.tft_dc;
                    mosi_nxt_s  = bus.tft_data[7];
                    sck_nxt_s   = 1'b0;
                    cs_n_nxt_s  = 1'b0;
                    busy_nxt_s  = 1'b1;
                end else begin
                    sck_nxt_s   = 1'b0;
                    mosi_nxt_s  = 1'b0;
                    cs_n_nxt_s  = 1'b1;
                    busy_nxt_s  = 1'b0;
                end
            end
            SHIFT: begin
                if (!expire_s) begin
                    state_nxt_s = SHIFT;
                end else if (bit_r == LAST_HALF) begin
                    state_nxt_s = HOLD;
                    sck_nxt_s   = 1'b0;
                end else if (is_rise_half(half_nxt_s)) begin
                    bit_nxt_s   = half_nxt_s;
                    sck_nxt_s   = 1'b1;
                end else begin
                    // Falling edge: present the next bit in the same cycle.
                    bit_nxt_s   = half_nxt_s;
                    sck_nxt_s   = 1'b0;
                    mosi_nxt_s  = shift_r[6];
                    shift_nxt_s = {shift_r[6:0], 1'b0};
                end
            end
            HOLD: begin
                if (expire_s) begin
                    state_nxt_s = GAP;
                    cs_n_nxt_s  = 1'b1;
                    mosi_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            GAP: begin
                if (expire_s) begin
                    state_nxt_s = IDLE;
                    busy_nxt_s  = 1'b0;
                end else begin
                    state_nxt_s = GAP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            bit_r   <= 4'd0;
            shift_r <= 8'h00;
            sck_r   <= 1'b0;
            mosi_r  <= 1'b0;
            dc_r    <= DC_COMM;
            cs_n_r  <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            bit_r   <= bit_nxt_s;
            shift_r <= shift_nxt_s;
            sck_r   <= sck_nxt_s;
            mosi_r  <= mosi_nxt_s;
            dc_r    <= dc_nxt_s;
            cs_n_r  <= cs_n_nxt_s;
            busy_r  <= busy_nxt_s;
        end
    end

    assign lcd_sck      = sck_r;
    assign lcd_mosi     = mosi_r;
    assign lcd_dc       = dc_r;
    assign lcd_cs_n     = cs_n_r;
    assign bus.tft_busy = busy_r;

`ifdef TFT_SPI_READ_EN
    logic [7:0] rx_shift_r, rx_data_r;
    logic       rx_valid_r;
    logic       rise_s, capture_s;

    assign rise_s    = (state_r == SHIFT) && expire_s && (bit_r != LAST_HALF) && is_rise_half(half_nxt_s);
    assign capture_s = (state_r == HOLD) && expire_s;

    // Sample miso on the edge that raises sck; publish the byte as CS deasserts.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_shift_r <= 8'h00;
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
        end else begin
            rx_shift_r <= rise_s ? {rx_shift_r[6:0], lcd_miso} : rx_shift_r;
            rx_data_r  <= capture_s ? rx_shift_r : rx_data_r;
            rx_valid_r <= capture_s;
        end
    end

    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
`endif

endmodule

// File: tb/tb_tft_spi_byte_tx.sv
// Scoreboard bench for tft_spi_byte_tx: a cycle-count model decides which
// strobes are accepted; a pin monitor decodes frames and compares them.
module tb_tft_spi_byte_tx;
    import tft_pkg::*;

    localparam int CLK_DIV = 2;
    localparam int CS_GAP  = 2;
    localparam int FRAME   = 17 * CLK_DIV + CS_GAP;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lcd_sck, lcd_mosi, lcd_dc, lcd_cs_n;
`ifdef TFT_SPI_READ_EN
    logic       lcd_miso = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
`endif

    tft_spi_byte_tx_if bus();

    tft_spi_byte_tx #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .lcd_sck  (lcd_sck),
        .lcd_mosi (lcd_mosi),
        .lcd_dc   (lcd_dc),
        .lcd_cs_n (lcd_cs_n)
`ifdef TFT_SPI_READ_EN
        ,
        .lcd_miso (lcd_miso),
        .rx_data  (rx_data),
        .rx_valid (rx_valid)
`endif
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    int         model_left = 0;
    logic [8:0] exp_q[$];
    int         gap_q[$];
    int         frame_abort = 0;
    int         busy_abort = 0;
    bit         chk_reset_pins = 1'b0;
    logic [7:0] miso_next = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: check busy against the model, drive inputs, advance the model.
    task automatic cycle(input logic r, input logic tr, input logic dc, input logic [7:0] d);
        @(negedge clk);
        check("busy", 32'(bus.tft_busy), 32'(model_left > 0));
        if (chk_reset_pins) begin
            check("rst_cs_n", 32'(lcd_cs_n), 32'd1);
            check("rst_sck", 32'(lcd_sck), 32'd0);
            check("rst_mosi", 32'(lcd_mosi), 32'd0);
            check("rst_dc", 32'(lcd_dc), 32'd0);
`ifdef TFT_SPI_READ_EN
            check("rst_rx_data", 32'(rx_data), 32'd0);
`endif
        end
        rst = r;
        bus.tft_transmit = tr;
        bus.tft_dc = dc;
        bus.tft_data = d;
        @(posedge clk);
        if (r) begin
            if (model_left > CS_GAP) frame_abort++;
            if (model_left > 0) busy_abort++;
            model_left = 0;
        end else if (tr && model_left == 0) begin
            exp_q.push_back({dc, d});
            model_left = FRAME;
        end else if (model_left > 0) begin
            model_left--;
        end
    endtask

    task automatic send(input logic dc, input logic [7:0] d);
        while (model_left != 0) cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, dc, d);
    endtask

    task automatic settle();
        while (model_left != 0) cycle(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // Pin monitor: decodes each CS-low frame and pops the scoreboard at its end.
    initial begin
        logic       pcs, psck, pmosi, pbusy, dcv, fend, ab;
        logic [7:0] rx, mb;
        logic [8:0] e;
        int         rises, busy_run, gap;
        bit         dc_ok, mosi_ok, have_end;
        pcs = 1'b1; psck = 1'b0; pmosi = 1'b0; pbusy = 1'b0; dcv = 1'b0;
        rx = 8'h00; mb = 8'h00; e = 9'h000;
        rises = 0; busy_run = 0; gap = 0;
        dc_ok = 1'b1; mosi_ok = 1'b1; have_end = 1'b0;
        forever begin
            @(negedge clk);
            fend = 1'b0;
            ab = 1'b0;
            if (pcs && !lcd_cs_n) begin
                if (have_end) begin
                    check("cs_gap_min", 32'(gap >= CS_GAP), 32'd1);
                    gap_q.push_back(gap);
                end
                rises = 0; rx = 8'h00; dcv = lcd_dc; dc_ok = 1'b1; mosi_ok = 1'b1;
                check("sck_at_cs_fall", 32'(lcd_sck), 32'd0);
                mb = miso_next;
                miso_next = 8'($urandom);
`ifdef TFT_SPI_READ_EN
                lcd_miso = mb[7];
`endif
            end else if (!pcs && !lcd_cs_n) begin
                if (lcd_dc !== dcv) dc_ok = 1'b0;
                if (lcd_mosi !== pmosi && !(psck && !lcd_sck)) mosi_ok = 1'b0;
                if (!psck && lcd_sck) begin
                    rx = {rx[6:0], lcd_mosi};
                    rises++;
`ifdef TFT_SPI_READ_EN
                    if (rises < 8) lcd_miso = mb[7 - rises];
`endif
                end
            end else if (!pcs && lcd_cs_n) begin
                fend = 1'b1;
                ab = (frame_abort > 0);
                check("frame_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) e = exp_q.pop_front();
                if (ab) begin
                    frame_abort--;
                    check("abort_partial", 32'(rises < 8), 32'd1);
                    have_end = 1'b0;
                end else begin
                    check("frame_byte", 32'(rx), 32'(e[7:0]));
                    check("sck_pulses", 32'(rises), 32'd8);
                    check("frame_dc", 32'(dcv), 32'(e[8]));
                    check("dc_stable", 32'(dc_ok), 32'd1);
                    check("mosi_on_fall_only", 32'(mosi_ok), 32'd1);
                    check("gap_mosi", 32'(lcd_mosi), 32'd0);
                    check("gap_sck", 32'(lcd_sck), 32'd0);
                    have_end = 1'b1;
                    gap = 1;
                end
            end else if (have_end) begin
                gap++;
            end
            if (bus.tft_busy) begin
                busy_run++;
            end else if (pbusy) begin
                if (busy_abort > 0) busy_abort--;
                else check("busy_len", 32'(busy_run), 32'(FRAME));
                busy_run = 0;
            end
`ifdef TFT_SPI_READ_EN
            check("rx_valid", 32'(rx_valid), 32'(fend && !ab));
            if (fend && !ab) check("rx_data", 32'(rx_data), 32'(mb));
`endif
            pcs = lcd_cs_n; psck = lcd_sck; pmosi = lcd_mosi; pbusy = bus.tft_busy;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Stimulus: directed frames, ignored strobes, mid-frame reset, then random traffic.
    initial begin
        int   n;
        logic ps;
        bus.tft_transmit = 1'b0;
        bus.tft_dc = 1'b0;
        bus.tft_data = 8'h00;
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 8'h00);
        chk_reset_pins = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        chk_reset_pins = 1'b0;

        send(DC_COMM, 8'hA5); settle();
        send(DC_DATA, 8'hFF); settle();
        send(DC_DATA, 8'h00); settle();

        send(DC_COMM, 8'h3C);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, DC_DATA, 8'h11);
        while (model_left != 1) cycle(1'b0, 1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, DC_DATA, 8'h5A);
        settle();

        send(DC_COMM, 8'h2A);
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        gap_q.delete();
        send(DC_DATA, 8'h00);
        send(DC_DATA, 8'hEF);
        settle();
        check("b2b_gap_count", 32'(gap_q.size()), 32'd2);
        foreach (gap_q[k]) check("b2b_gap", 32'(gap_q[k]), 32'(CS_GAP + 1));

        send(DC_COMM, 8'hF0);
        n = 0;
        ps = 1'b0;
        for (int k = 0; k < 200 && n < 4; k++) begin
            cycle(1'b0, 1'b0, 1'b0, 8'h00);
            #1;
            if (!ps && lcd_sck) n++;
            ps = lcd_sck;
        end
        check("fourth_rise_reached", 32'(n), 32'd4);
        cycle(1'b1, 1'b0, 1'b0, 8'h00);
        chk_reset_pins = 1'b1;
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        chk_reset_pins = 1'b0;
        send(DC_COMM, 8'h81); settle();

`ifdef TFT_SPI_READ_EN
        miso_next = 8'hC3;
        send(DC_DATA, 8'($urandom)); settle();
`endif

        for (int i = 0; i < 1500; i++)
            cycle(1'b0, ($urandom_range(0, 7) == 0), 1'($urandom), 8'($urandom));
        settle();
        check("drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
